adder_share_arb: RTL
====================

Name: adder_share_arb

Overview:
Round-robin arbiter and sequencer that shares one external 32-bit combinational adder (the carry-select adder, CSA_32 class) between NUM_REQ requesters, e.g. ALU, branch-target and PC-increment paths.
- Accepts one operation per cycle over valid/ready handshakes.
- Muxes the winner's operands onto the adder.
- Registers the sum/carry into a single output slot with its own valid/ready handshake.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept (combinational).
- req_a  input  NUM_REQ*32  operand A; slice i = [32*i+31:32*i].
- req_b  input  NUM_REQ*32  operand B, same slicing.
- req_cin  input  NUM_REQ  carry-in per requester.
- add_a  output  32  operand A to shared adder.
- add_b  output  32  operand B to shared adder.
- add_cin  output  1  carry-in to shared adder.
- add_sum  input  32  adder sum (combinational return).
- add_cout  input  1  adder carry-out.
- rsp_valid  output  1  result slot full.
- rsp_ready  input  1  consumer takes the result.
- rsp_sum  output  32  registered sum.
- rsp_cout  output  1  registered carry-out.
- rsp_id  output  ID_W  index of the requester owning the result.

Behaviour:
- Reset (async, rst_n=0): rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, priority pointer ptr=0. An in-flight result is discarded. req_ready is 0 during reset.
- can_accept = !rsp_valid || rsp_ready (slot empty or drained this cycle).
- Winner w: first i with req_valid[i]=1, searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1 (wrap).
- req_ready[i] = can_accept && any req_valid && (i==w). At most one req_ready is high.
- add_a/add_b/add_cin carry the winner's operands whenever any req_valid is high, regardless of can_accept. They are 0 when no request is valid.
- Accept cycle (req_valid[w] && req_ready[w]) on the next edge:
  - rsp_sum <= add_sum
  - rsp_cout <= add_cout
  - rsp_id <= w
  - rsp_valid <= 1
  - ptr <= (w+1) mod NUM_REQ
- No accept and rsp_ready && rsp_valid: rsp_valid <= 0; data regs hold their values.
- Stall (rsp_valid && !rsp_ready): all req_ready=0. Rsp outputs are held bit-stable. ptr does not change.
- Latency: 1 cycle from accept to rsp_valid. Throughput: 1 op/cycle with rsp_ready held at 1.
- Requesters hold valid and operands stable until accepted. The arbiter needs no internal operand storage.
- Simultaneous drain and accept: the slot is overwritten with the new result; rsp_valid stays 1.
- Arithmetic: 32-bit modulo sum. Cout is passed through unmodified; no overflow flag.

Optional Feature:
ADD_ARB_CHAIN_EN
- Defined:
  - Adds input req_chain (NUM_REQ bits).
  - An accepted beat with req_chain[w]=1 sets lock=1 and lock_id=w, and stores cout_q=add_cout.
  - While locked, only lock_id can be granted, and ptr is not advanced.
  - The locked requester's add_cin is cout_q; its req_cin is ignored.
  - An accepted beat with req_chain=0 from lock_id clears lock and advances ptr normally.
  - Reset clears lock and cout_q.
  - Use case: multi-word (64-bit) additions.
- Undefined: port absent, no lock state, pure round robin as above.

Test Plan:
1. Req0 only: a=0xFFFFFFFF, b=0x1, cin=0 -> req_ready[0]=1 same cycle. Next cycle: rsp_valid=1, rsp_sum=0x0, rsp_cout=1, rsp_id=0.
2. Req0..2 valid every cycle, rsp_ready=1 -> grant order 0,1,2,0,1,2, one accept per cycle, rsp_id follows one cycle later.
3. Backpressure: rsp_valid=1 with sum=0x12345678, rsp_ready=0 for 3 cycles, req1 valid -> req_ready=000, outputs stable. Raise rsp_ready -> req1 accepted that cycle, new result next cycle.
4. Pointer wrap: after grant to 1 (ptr=2), req0 and req2 valid -> grant 2 first, then 0.
5. Reset mid-op: drop rst_n while rsp_valid=1 and req valid -> rsp_valid=0 asynchronously. After release, first grant goes to lowest valid index (ptr=0).
6. (ADD_ARB_CHAIN_EN) Req1 chain=1: a=0xFFFFFFFF, b=1, then chain=0: a=0, b=0, with req0 valid throughout -> beats 1,1 give sums 0x0 (cout=1) and 0x1 (cout=0), then req0 is granted.

Source files
------------

// File: rtl/adder_share_arb_if.sv
// Handshake bundle between NUM_REQ requesters, the shared external adder and the result consumer.
// Optional macro ADD_ARB_CHAIN_EN adds the per-requester req_chain lock request.
interface adder_share_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ-1:0]    req_cin;
`ifdef ADD_ARB_CHAIN_EN
  logic [NUM_REQ-1:0]    req_chain;
`endif
  logic [31:0]           add_a;
  logic [31:0]           add_b;
  logic                  add_cin;
  logic [31:0]           add_sum;
  logic                  add_cout;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_sum;
  logic                  rsp_cout;
  logic [ID_W-1:0]       rsp_id;

  modport slave (
`ifdef ADD_ARB_CHAIN_EN
    input  req_chain,
`endif
    input  req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );

  modport master (
`ifdef ADD_ARB_CHAIN_EN
    output req_chain,
`endif
    output req_valid, req_a, req_b, req_cin, add_sum, add_cout, rsp_ready,
    input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_sum, rsp_cout, rsp_id
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one external 32-bit adder, with a single registered result slot.
// Optional macro ADD_ARB_CHAIN_EN: chained multi-word adds lock the grant and forward carry.
module adder_share_arb #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_share_arb_if.slave bus
);

  logic                r_rsp_valid;
  logic [31:0]         r_rsp_sum;
  logic                r_rsp_cout;
  logic [ID_W-1:0]     r_rsp_id;
  logic [ID_W-1:0]     r_ptr;

  logic                w_any;
  logic [ID_W-1:0]     w_win;
  logic [ID_W:0]       w_idx;
  logic                w_can_accept;
  logic                w_accept;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic [NUM_REQ-1:0]  w_ready;
  logic [31:0]         w_add_a;
  logic [31:0]         w_add_b;
  logic                w_add_cin;

`ifdef ADD_ARB_CHAIN_EN
  logic                r_lock;
  logic [ID_W-1:0]     r_lock_id;
  logic                r_cout_q;
`endif

  assign w_can_accept = !r_rsp_valid || bus.rsp_ready;
  assign w_accept     = rst_n && w_can_accept && w_any;
  assign w_ptr_nxt    = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);

  // Winner search: first valid requester starting at r_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      end else begin
        w_idx = w_idx;
      end
      if (!w_any && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[ID_W-1:0];
      end else begin
        w_any = w_any;
      end
    end
`ifdef ADD_ARB_CHAIN_EN
    // A chain in progress owns the adder until its closing beat.
    if (r_lock) begin
      w_any = bus.req_valid[r_lock_id];
      w_win = r_lock_id;
    end else begin
      w_win = w_win;
    end
`endif
  end

  // Grant decode and operand mux onto the shared adder.
  always_comb begin
    w_ready   = '0;
    w_add_a   = 32'd0;
    w_add_b   = 32'd0;
    w_add_cin = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_any && (w_win == ID_W'(i))) begin
        w_ready[i] = rst_n && w_can_accept;
        w_add_a    = bus.req_a[32*i +: 32];
        w_add_b    = bus.req_b[32*i +: 32];
        w_add_cin  = bus.req_cin[i];
      end else begin
        w_ready[i] = 1'b0;
      end
    end
`ifdef ADD_ARB_CHAIN_EN
    if (r_lock && w_any) begin
      w_add_cin = r_cout_q;
    end else begin
      w_add_cin = w_add_cin;
    end
`endif
  end

  // Result slot and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= 32'd0;
      r_rsp_cout  <= 1'b0;
      r_rsp_id    <= '0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_sum   <= bus.add_sum;
      r_rsp_cout  <= bus.add_cout;
      r_rsp_id    <= w_win;
`ifdef ADD_ARB_CHAIN_EN
      if (!bus.req_chain[w_win]) begin
        r_ptr <= w_ptr_nxt;
      end else begin
        r_ptr <= r_ptr;
      end
`else
      r_ptr <= w_ptr_nxt;
`endif
    end else if (r_rsp_valid && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= r_rsp_valid;
    end
  end

`ifdef ADD_ARB_CHAIN_EN
  // Chain lock state and carry forwarded between beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_cout_q  <= 1'b0;
    end else if (w_accept && bus.req_chain[w_win]) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_win;
      r_cout_q  <= bus.add_cout;
    end else if (w_accept) begin
      r_lock    <= 1'b0;
    end else begin
      r_lock    <= r_lock;
    end
  end
`endif

  assign bus.req_ready = w_ready;
  assign bus.add_a     = w_add_a;
  assign bus.add_b     = w_add_b;
  assign bus.add_cin   = w_add_cin;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_sum   = r_rsp_sum;
  assign bus.rsp_cout  = r_rsp_cout;
  assign bus.rsp_id    = r_rsp_id;

endmodule
